// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential radix-2 Booth signed multiplier (M * Q -> 2*WIDTH-bit product).
// Latency: start accepted at edge k; busy high after edges k..k+WIDTH; done pulse with product after edge k+WIDTH+1.
// Backpressure: start is ignored while busy; a start during the done cycle is accepted back-to-back.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         operation request, sampled only when not busy
//   multiplicand  signed operand M, latched on an accepted start
//   multiplier    signed operand Q, latched on an accepted start
//   product       signed M*Q, held from one done until the next done
//   busy          high while iterating
//   done          one-cycle pulse marking a fresh product
module booth_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  // Accumulator and multiplicand copies are one bit wider than the operands so
  // that negating the most negative multiplicand is exact.
  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] neg_m;
  logic [WIDTH:0] acc;
  logic [WIDTH-1:0] q;
  logic           q_1;
  logic [CW-1:0]  count;

  logic [WIDTH:0] m_in_ext;
  logic [WIDTH:0] addend;
  logic [WIDTH:0] sum;

  assign m_in_ext = {multiplicand[WIDTH-1], multiplicand};

  // Booth recoding of the current pair {Q[0], q_-1}; carry-out of the add is dropped.
  always_comb begin
    addend = '0;
    case ({q[0], q_1})
      2'b01:   addend = m_ext;
      2'b10:   addend = neg_m;
      default: addend = '0;
    endcase
    sum = acc + addend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      m_ext   <= '0;
      neg_m   <= '0;
      acc     <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      count   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            m_ext <= m_in_ext;
            neg_m <= ~m_in_ext + {{WIDTH{1'b0}}, 1'b1};
            acc   <= '0;
            q     <= multiplier;
            q_1   <= 1'b0;
            count <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (count != '0) begin
            // Arithmetic right shift of {A, Q, q_-1} applied to the updated A.
            acc   <= {sum[WIDTH], sum[WIDTH:1]};
            q     <= {sum[0], q[WIDTH-1:1]};
            q_1   <= q[0];
            count <= count - 1'b1;
          end else begin
            // All WIDTH iterations done: the low WIDTH bits of A plus Q form the product.
            product <= {acc[WIDTH-1:0], q};
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
module tb_booth_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [63:0] product;
  logic        busy;
  logic        done;

  int checks;
  int errors;

  logic [63:0] expq[$];

  booth_multiplier #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
    longint sm;
    longint sq;
    sm = longint'($signed(m));
    sq = longint'($signed(q));
    return 64'(sm * sq);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
    end
  endtask

  // Waits (at negedges) for done; returns number of negedges waited, -1 on timeout.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      check("done_timeout", 64'(n), 64'd34);
      n = -1;
    end
  endtask

  // Compare product on the done cycle against the scoreboard head.
  task automatic score(input string tag);
    logic [63:0] e;
    if (expq.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = expq.pop_front();
      check(tag, product, e);
    end
    check({tag, "_busy_on_done"}, 64'(busy), 64'd0);
  endtask

  // One isolated operation: start for one cycle, scramble operands afterwards.
  task automatic run_op(input string tag, input logic [31:0] m, input logic [31:0] q);
    int n;
    logic [63:0] held;
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    expq.push_back(ref_mul(m, q));
    @(negedge clk);
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    wait_done(n);
    if (n >= 0) begin
      score(tag);
      held = product;
      @(negedge clk);
      check({tag, "_done_width"}, 64'(done), 64'd0);
      check({tag, "_hold"}, product, held);
    end
  endtask

  initial begin
    int n;
    int busy_cycles;
    logic [31:0] rm;
    logic [31:0] rq;

    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = 32'h1234_5678;
    multiplier   = 32'h8765_4321;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_product", product, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: 7 * -3 with exact latency and busy-width checks
    multiplicand = 32'd7;
    multiplier   = 32'hFFFF_FFFD;
    start        = 1'b1;
    expq.push_back(64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk);
    start        = 1'b0;
    multiplicand = 32'd100;
    multiplier   = 32'd100;
    n            = 0;
    busy_cycles  = 0;
    while (!done && n < 100) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      n++;
    end
    check("t1_latency", 64'(n), 64'd33);
    check("t1_busy_cycles", 64'(busy_cycles), 64'd33);
    if (done) score("t1_product");
    @(negedge clk);
    check("t1_done_width", 64'(done), 64'd0);
    check("t1_busy_after", 64'(busy), 64'd0);

    // Test 2/3: most-negative operands
    run_op("t2_minmin", 32'h8000_0000, 32'h8000_0000);
    run_op("t3_min_m1", 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("t3_m1_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Test 4: start held high, operand changes while busy, back-to-back restart
    multiplicand = 32'd5;
    multiplier   = 32'd6;
    start        = 1'b1;
    expq.push_back(64'd30);
    @(negedge clk);
    multiplicand = 32'd9;
    multiplier   = 32'd9;
    wait_done(n);
    if (n >= 0) begin
      score("t4_first");
      expq.push_back(64'd81);
      @(negedge clk);
      check("t4_restart_busy", 64'(busy), 64'd1);
      check("t4_restart_done", 64'(done), 64'd0);
      check("t4_product_held", product, 64'd30);
      wait_done(n);
      start = 1'b0;
      if (n >= 0) begin
        check("t4_second_latency", 64'(n), 64'd33);
        score("t4_second");
      end
    end
    @(negedge clk);
    check("t4_idle_after", 64'(busy), 64'd0);

    // Test 5: reset at iteration 10 aborts without a done pulse
    multiplicand = 32'd3;
    multiplier   = 32'd4;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    check("t5_product", product, 64'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    check("t5_no_done", 64'(n), 64'd0);
    run_op("t5_fresh", 32'd3, 32'd4);

    // Test 6: random signed pairs plus a few corners
    run_op("corner_max_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    run_op("corner_max_min", 32'h7FFF_FFFF, 32'h8000_0000);
    run_op("corner_zero", 32'h0000_0000, 32'h8000_0000);
    for (int i = 0; i < 300; i++) begin
      rm = $urandom;
      rq = $urandom;
      if (i % 16 == 0) rq = {32{rq[0]}};
      run_op("random", rm, rq);
    end

    check("scoreboard_drained", 64'(expq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
